// File: rtl/bus_addr_decoder.sv
// bus_addr_decoder: 8088 peripheral bus front end.
// Demultiplexes the address on ALE, decodes four one-hot chip selects,
// stretches the command with programmable wait states through READY and
// pulses CYCLE_ERR on malformed or timed-out bus cycles.
//
// Handshake: the CPU starts a cycle with ALE, then drops RD_N or WR_N.
// The command completes on the first cycle READY is sampled high while the
// strobe is low; the cycle ends when both strobes return high.
module bus_addr_decoder #(
  parameter int unsigned WS0     = 1,
  parameter int unsigned WS1     = 0,
  parameter int unsigned WS2     = 2,
  parameter int unsigned WS3     = 3,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ALE,
  input  logic        IOM,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [19:0] A,
  output logic [19:0] Address,
  output logic [3:0]  CS,
  output logic        READY,
  output logic        CYCLE_ERR,
  output logic [4:0]  state_dbg
);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    ADDR = 5'b00010,
    CMD  = 5'b00100,
    HOLD = 5'b01000,
    ERR  = 5'b10000
  } state_t;

  // Last ADDR cycle before the timeout fires (counter counts from 0).
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [19:0] hold_addr;
  logic        hold_iom;
  logic [3:0]  sel_cs;
  logic [2:0]  wait_cnt;
  logic [7:0]  tmo_cnt;

  logic        ale_ok;
  logic [19:0] eff_addr;
  logic        eff_iom;
  logic [3:0]  cs_dec;
  logic        both_low, any_low;
  logic        load_sel, clr_tmo, inc_tmo, load_wait, dec_wait;

  // Memory map: two 512K memory halves, IO FF00-FF0F and IO 1C00-1DFF.
  function automatic logic [3:0] decode(input logic [19:0] addr, input logic iom);
    logic [3:0] cs;
    cs = 4'b0000;
    if (iom) begin
      cs[2] = (addr[15:4] == 12'hFF0);
      cs[3] = (addr[15:9] == 7'h0E);
    end else begin
      cs[0] = !addr[19];
      cs[1] = addr[19];
    end
    return cs;
  endfunction

  // Wait-state count for the selected slave; a decode miss gets none.
  function automatic logic [2:0] ws_of(input logic [3:0] sel);
    logic [2:0] ws;
    ws = 3'd0;
    if (sel[0])      ws = 3'(WS0);
    else if (sel[1]) ws = 3'(WS1);
    else if (sel[2]) ws = 3'(WS2);
    else if (sel[3]) ws = 3'(WS3);
    return ws;
  endfunction

  // ALE only opens the latch between cycles; once a command is running it is ignored.
  assign ale_ok   = ALE && (state == IDLE || state == ADDR);
  assign eff_addr = ale_ok ? A   : hold_addr;
  assign eff_iom  = ale_ok ? IOM : hold_iom;
  assign cs_dec   = decode(eff_addr, eff_iom);
  assign both_low = !RD_N && !WR_N;
  assign any_low  = !RD_N || !WR_N;

  // Outputs: transparent address, gated chip selects, READY and error pulse.
  always_comb begin
    Address   = eff_addr;
    CS        = 4'b0000;
    READY     = 1'b1;
    CYCLE_ERR = 1'b0;
    if (ale_ok || state == ADDR || state == CMD || state == HOLD) CS = cs_dec;
    if (state == CMD && wait_cnt != 3'd0) READY = 1'b0;
    if (state == ERR) CYCLE_ERR = 1'b1;
  end

  assign state_dbg = state;

  // Next-state logic and datapath control strobes.
  always_comb begin
    state_nxt = state;
    load_sel  = 1'b0;
    clr_tmo   = 1'b0;
    inc_tmo   = 1'b0;
    load_wait = 1'b0;
    dec_wait  = 1'b0;
    case (state)
      IDLE: begin
        if (ALE) begin
          state_nxt = ADDR;
          load_sel  = 1'b1;
          clr_tmo   = 1'b1;
        end
      end
      ADDR: begin
        if (both_low) begin
          state_nxt = ERR;
        end else if (any_low) begin
          state_nxt = CMD;
          load_wait = 1'b1;
        end else if (ALE) begin
          load_sel = 1'b1;
          clr_tmo  = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ERR;
        end else begin
          inc_tmo = 1'b1;
        end
      end
      CMD: begin
        if (both_low)                state_nxt = ERR;
        else if (wait_cnt == 3'd0)   state_nxt = HOLD;
        else                         dec_wait  = 1'b1;
      end
      HOLD: begin
        if (both_low)          state_nxt = ERR;
        else if (RD_N && WR_N) state_nxt = IDLE;
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Address/IOM holding register, slave select and wait/timeout counters.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      hold_addr <= 20'h0_0000;
      hold_iom  <= 1'b0;
      sel_cs    <= 4'b0000;
      wait_cnt  <= 3'd0;
      tmo_cnt   <= 8'd0;
    end else begin
      if (ale_ok) begin
        hold_addr <= A;
        hold_iom  <= IOM;
      end
      if (load_sel)       sel_cs   <= cs_dec;
      if (clr_tmo)        tmo_cnt  <= 8'd0;
      else if (inc_tmo)   tmo_cnt  <= tmo_cnt + 8'd1;
      if (load_wait)      wait_cnt <= ws_of(sel_cs);
      else if (dec_wait)  wait_cnt <= wait_cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_bus_addr_decoder.sv
// tb_bus_addr_decoder: directed scenarios for bus_addr_decoder with
// hand-computed expectations (default parameters WS0=1 WS1=0 WS2=2 WS3=3
// TIMEOUT=8). Inputs change 1 ns after the rising edge, outputs are
// sampled 3 ns after the rising edge.
module tb_bus_addr_decoder;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_ERR  = 5'b10000;

  logic        CLK = 1'b0;
  logic        RESET_N, ALE, IOM, RD_N, WR_N;
  logic [19:0] A;
  logic [19:0] Address;
  logic [3:0]  CS;
  logic        READY, CYCLE_ERR;
  logic [4:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  bus_addr_decoder dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .ALE       (ALE),
    .IOM       (IOM),
    .RD_N      (RD_N),
    .WR_N      (WR_N),
    .A         (A),
    .Address   (Address),
    .CS        (CS),
    .READY     (READY),
    .CYCLE_ERR (CYCLE_ERR),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog.
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Driver: one full bus cycle. ALE for one cycle, then a strobe held low
  // for strobe_len cycles, then strobes released and one more cycle.
  task automatic bus_cycle(
    input  logic [19:0] addr,
    input  logic        iom,
    input  logic        wr,
    input  int          strobe_len,
    output logic [3:0]  cs_ale,
    output logic [19:0] addr_ale,
    output logic [19:0] addr_held,
    output logic        cs_steady,
    output int          ready_lows,
    output logic        err_seen,
    output logic [3:0]  cs_after,
    output logic [4:0]  state_after
  );
    ready_lows = 0;
    err_seen   = 1'b0;
    cs_steady  = 1'b1;
    tick;
    ALE = 1'b1; A = addr; IOM = iom;
    #2;
    cs_ale   = CS;
    addr_ale = Address;
    tick;
    ALE = 1'b0; A = 20'h5_A5A5; IOM = !iom;
    if (wr) WR_N = 1'b0; else RD_N = 1'b0;
    #2;
    addr_held = Address;
    if (CS !== cs_ale) cs_steady = 1'b0;
    if (READY !== 1'b1) ready_lows++;
    if (CYCLE_ERR !== 1'b0) err_seen = 1'b1;
    for (int i = 1; i < strobe_len; i++) begin
      tick;
      #2;
      if (CS !== cs_ale) cs_steady = 1'b0;
      if (READY !== 1'b1) ready_lows++;
      if (CYCLE_ERR !== 1'b0) err_seen = 1'b1;
    end
    tick;
    RD_N = 1'b1; WR_N = 1'b1;
    #2;
    if (CS !== cs_ale) cs_steady = 1'b0;
    if (READY !== 1'b1) ready_lows++;
    if (CYCLE_ERR !== 1'b0) err_seen = 1'b1;
    tick;
    #2;
    cs_after    = CS;
    state_after = state_dbg;
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; ALE = 1'b0; IOM = 1'b0; RD_N = 1'b1; WR_N = 1'b1; A = 20'hA_BCDE;
    repeat (3) tick;
    #2;
    checks++; if (Address !== 20'h0_0000) begin failures++; $display("FAIL reset_address got=%h exp=00000", Address); end
    checks++; if (CS !== 4'b0000) begin failures++; $display("FAIL reset_cs got=%b exp=0000", CS); end
    checks++; if (READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", READY); end
    checks++; if (CYCLE_ERR !== 1'b0) begin failures++; $display("FAIL reset_cycle_err got=%b exp=0", CYCLE_ERR); end
    checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL reset_state got=%b exp=%b", state_dbg, S_IDLE); end
    RESET_N = 1'b1;
  endtask

  task automatic test_mem_read;
    logic [3:0] cs_ale, cs_after; logic [19:0] a_ale, a_held; logic steady, err; int lows; logic [4:0] st;
    bus_cycle(20'h0_1234, 1'b0, 1'b0, 4, cs_ale, a_ale, a_held, steady, lows, err, cs_after, st);
    checks++; if (a_ale !== 20'h0_1234) begin failures++; $display("FAIL mem_rd_addr_ale got=%h exp=01234", a_ale); end
    checks++; if (a_held !== 20'h0_1234) begin failures++; $display("FAIL mem_rd_addr_held got=%h exp=01234", a_held); end
    checks++; if (cs_ale !== 4'b0001) begin failures++; $display("FAIL mem_rd_cs got=%b exp=0001", cs_ale); end
    checks++; if (steady !== 1'b1) begin failures++; $display("FAIL mem_rd_cs_steady got=%b exp=1", steady); end
    checks++; if (lows !== 1) begin failures++; $display("FAIL mem_rd_ready_lows got=%0d exp=1", lows); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL mem_rd_err got=%b exp=0", err); end
    checks++; if (cs_after !== 4'b0000) begin failures++; $display("FAIL mem_rd_cs_after got=%b exp=0000", cs_after); end
    checks++; if (st !== S_IDLE) begin failures++; $display("FAIL mem_rd_state_after got=%b exp=%b", st, S_IDLE); end
    checks++; if (Address !== 20'h0_1234) begin failures++; $display("FAIL mem_rd_addr_idle got=%h exp=01234", Address); end
  endtask

  task automatic test_io_write;
    logic [3:0] cs_ale, cs_after; logic [19:0] a_ale, a_held; logic steady, err; int lows; logic [4:0] st;
    bus_cycle(20'h0_FF05, 1'b1, 1'b1, 4, cs_ale, a_ale, a_held, steady, lows, err, cs_after, st);
    checks++; if (cs_ale !== 4'b0100) begin failures++; $display("FAIL io_wr_cs got=%b exp=0100", cs_ale); end
    checks++; if (steady !== 1'b1) begin failures++; $display("FAIL io_wr_cs_steady got=%b exp=1", steady); end
    checks++; if (lows !== 2) begin failures++; $display("FAIL io_wr_ready_lows got=%0d exp=2", lows); end
    checks++; if (cs_after !== 4'b0000) begin failures++; $display("FAIL io_wr_cs_after got=%b exp=0000", cs_after); end
    checks++; if (st !== S_IDLE) begin failures++; $display("FAIL io_wr_state_after got=%b exp=%b", st, S_IDLE); end
  endtask

  task automatic test_upper_and_unmapped;
    logic [3:0] cs_ale, cs_after; logic [19:0] a_ale, a_held; logic steady, err; int lows; logic [4:0] st;
    bus_cycle(20'h8_0000, 1'b0, 1'b0, 3, cs_ale, a_ale, a_held, steady, lows, err, cs_after, st);
    checks++; if (cs_ale !== 4'b0010) begin failures++; $display("FAIL upper_cs got=%b exp=0010", cs_ale); end
    checks++; if (lows !== 0) begin failures++; $display("FAIL upper_ready_lows got=%0d exp=0", lows); end
    checks++; if (a_held !== 20'h8_0000) begin failures++; $display("FAIL upper_addr_held got=%h exp=80000", a_held); end
    bus_cycle(20'h0_0300, 1'b1, 1'b0, 3, cs_ale, a_ale, a_held, steady, lows, err, cs_after, st);
    checks++; if (cs_ale !== 4'b0000) begin failures++; $display("FAIL unmapped_cs got=%b exp=0000", cs_ale); end
    checks++; if (steady !== 1'b1) begin failures++; $display("FAIL unmapped_cs_steady got=%b exp=1", steady); end
    checks++; if (lows !== 0) begin failures++; $display("FAIL unmapped_ready_lows got=%0d exp=0", lows); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL unmapped_err got=%b exp=0", err); end
    checks++; if (st !== S_IDLE) begin failures++; $display("FAIL unmapped_state_after got=%b exp=%b", st, S_IDLE); end
  endtask

  task automatic test_timeout;
    int early_err;
    logic [3:0] cs_ale, cs_after; logic [19:0] a_ale, a_held; logic steady, err; int lows; logic [4:0] st;
    early_err = 0;
    tick;
    ALE = 1'b1; A = 20'h0_1234; IOM = 1'b0;
    tick;
    ALE = 1'b0;
    // Eight ADDR cycles with no strobe: no error yet, CS still valid.
    for (int i = 1; i <= 8; i++) begin
      #2;
      if (CYCLE_ERR !== 1'b0 || CS !== 4'b0001) early_err++;
      tick;
    end
    #2;
    checks++; if (early_err !== 0) begin failures++; $display("FAIL tmo_early got=%0d bad cycles exp=0", early_err); end
    checks++; if (CYCLE_ERR !== 1'b1) begin failures++; $display("FAIL tmo_cycle_err got=%b exp=1", CYCLE_ERR); end
    checks++; if (CS !== 4'b0000) begin failures++; $display("FAIL tmo_cs got=%b exp=0000", CS); end
    checks++; if (READY !== 1'b1) begin failures++; $display("FAIL tmo_ready got=%b exp=1", READY); end
    tick;
    #2;
    checks++; if (CYCLE_ERR !== 1'b0) begin failures++; $display("FAIL tmo_pulse_len got=%b exp=0", CYCLE_ERR); end
    checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL tmo_state got=%b exp=%b", state_dbg, S_IDLE); end
    bus_cycle(20'h8_0000, 1'b0, 1'b0, 3, cs_ale, a_ale, a_held, steady, lows, err, cs_after, st);
    checks++; if (cs_ale !== 4'b0010) begin failures++; $display("FAIL tmo_next_cs got=%b exp=0010", cs_ale); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmo_next_err got=%b exp=0", err); end
  endtask

  task automatic test_both_strobes;
    tick;
    ALE = 1'b1; A = 20'h0_FF05; IOM = 1'b1;
    tick;
    ALE = 1'b0; WR_N = 1'b0;
    tick;
    #2;
    checks++; if (READY !== 1'b0) begin failures++; $display("FAIL both_wait_ready got=%b exp=0", READY); end
    RD_N = 1'b0;
    tick;
    #2;
    checks++; if (CYCLE_ERR !== 1'b1) begin failures++; $display("FAIL both_cycle_err got=%b exp=1", CYCLE_ERR); end
    checks++; if (READY !== 1'b1) begin failures++; $display("FAIL both_ready got=%b exp=1", READY); end
    checks++; if (CS !== 4'b0000) begin failures++; $display("FAIL both_cs got=%b exp=0000", CS); end
    RD_N = 1'b1; WR_N = 1'b1;
    tick;
    #2;
    checks++; if (CYCLE_ERR !== 1'b0) begin failures++; $display("FAIL both_pulse_len got=%b exp=0", CYCLE_ERR); end
    checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL both_state got=%b exp=%b", state_dbg, S_IDLE); end
  endtask

  task automatic test_reset_mid_cycle;
    logic [3:0] cs_ale, cs_after; logic [19:0] a_ale, a_held; logic steady, err; int lows; logic [4:0] st;
    tick;
    ALE = 1'b1; A = 20'h0_1C40; IOM = 1'b1;
    tick;
    ALE = 1'b0; RD_N = 1'b0;
    tick;
    #2;
    checks++; if (CS !== 4'b1000) begin failures++; $display("FAIL rst_mid_cs_before got=%b exp=1000", CS); end
    checks++; if (READY !== 1'b0) begin failures++; $display("FAIL rst_mid_ready_before got=%b exp=0", READY); end
    RESET_N = 1'b0;
    tick;
    #2;
    checks++; if (READY !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", READY); end
    checks++; if (CS !== 4'b0000) begin failures++; $display("FAIL rst_mid_cs got=%b exp=0000", CS); end
    checks++; if (Address !== 20'h0_0000) begin failures++; $display("FAIL rst_mid_address got=%h exp=00000", Address); end
    RESET_N = 1'b1; RD_N = 1'b1;
    tick;
    bus_cycle(20'h0_1C40, 1'b1, 1'b0, 5, cs_ale, a_ale, a_held, steady, lows, err, cs_after, st);
    checks++; if (cs_ale !== 4'b1000) begin failures++; $display("FAIL rst_after_cs got=%b exp=1000", cs_ale); end
    checks++; if (lows !== 3) begin failures++; $display("FAIL rst_after_ready_lows got=%0d exp=3", lows); end
    checks++; if (st !== S_IDLE) begin failures++; $display("FAIL rst_after_state got=%b exp=%b", st, S_IDLE); end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_io_write();
    test_upper_and_unmapped();
    test_timeout();
    test_both_strobes();
    test_reset_mid_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
